// File: rtl/halfwave_pwm.sv
// Two-pin PWM output stage for a split positive/negative half-wave sample stream.
// Paces the generator with sample_req, double-buffers each sample and adds dead time on polarity changes.
module halfwave_pwm #(
    parameter int PWM_BITS    = 8,
    parameter int SAMPLE_DIV  = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] pos_in,
    input  logic [PWM_BITS-1:0] neg_in,
    output logic                sample_req,
    output logic                pwm_pos,
    output logic                pwm_neg,
    output logic                period_start,
    output logic                fault
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] CTR_LAST = '1;
    localparam logic [PWM_BITS-1:0] REQ_AT   = CTR_LAST - PWM_BITS'(3);
    localparam logic [PWM_BITS-1:0] CAP_AT   = CTR_LAST - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DEAD     = PWM_BITS'(DEAD_CYCLES);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic { OFF, RUN } state_t;
    typedef enum logic [1:0] { POL_ZERO, POL_POS, POL_NEG } pol_t;

    state_t              state;
    logic [PWM_BITS-1:0] pwm_ctr;
    logic [DIV_W-1:0]    div_ctr;
    pol_t                act_pol;
    pol_t                shd_pol;
    pol_t                last_pol;
    logic [PWM_BITS-1:0] act_duty;
    logic [PWM_BITS-1:0] shd_duty;
    logic                guard;

    pol_t                in_pol;
    logic [PWM_BITS-1:0] in_duty;
    logic                in_fault;
    logic [PWM_BITS-1:0] ctr_next;
    logic                wrap;
    logic                fetch_period;
    logic                drive_on;
    logic                new_guard;

    // A sample with both halves nonzero is illegal and decodes to silence.
    always_comb begin
        in_pol   = POL_ZERO;
        in_duty  = '0;
        in_fault = 1'b0;
        if (pos_in != '0 && neg_in == '0) begin
            in_pol  = POL_POS;
            in_duty = pos_in;
        end else if (neg_in != '0 && pos_in == '0) begin
            in_pol  = POL_NEG;
            in_duty = neg_in;
        end else if (pos_in != '0 && neg_in != '0) begin
            in_fault = 1'b1;
        end
    end

    assign ctr_next     = pwm_ctr + 1'b1;
    assign wrap         = (pwm_ctr == CTR_LAST);
    assign fetch_period = (div_ctr == DIV_LAST);
    assign drive_on     = (pwm_ctr < act_duty) && !(guard && (pwm_ctr < DEAD));
    assign new_guard    = (shd_pol != POL_ZERO) && (shd_pol != last_pol);

    // Outputs are computed from the current counter and registered, so pins lag the counter by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= OFF;
            pwm_ctr      <= '0;
            div_ctr      <= '0;
            act_pol      <= POL_ZERO;
            shd_pol      <= POL_ZERO;
            last_pol     <= POL_ZERO;
            act_duty     <= '0;
            shd_duty     <= '0;
            guard        <= 1'b0;
            sample_req   <= 1'b0;
            pwm_pos      <= 1'b0;
            pwm_neg      <= 1'b0;
            period_start <= 1'b0;
            fault        <= 1'b0;
        end else if (state == OFF || !enable) begin
            pwm_ctr      <= '0;
            act_pol      <= POL_ZERO;
            shd_pol      <= POL_ZERO;
            last_pol     <= POL_ZERO;
            act_duty     <= '0;
            shd_duty     <= '0;
            guard        <= 1'b0;
            sample_req   <= 1'b0;
            pwm_pos      <= 1'b0;
            pwm_neg      <= 1'b0;
            if (state == OFF && enable) begin
                state        <= RUN;
                div_ctr      <= DIV_LAST;
                period_start <= 1'b1;
            end else begin
                state        <= OFF;
                div_ctr      <= '0;
                period_start <= 1'b0;
            end
        end else begin
            pwm_ctr      <= ctr_next;
            period_start <= wrap;
            sample_req   <= fetch_period && (ctr_next == REQ_AT);
            pwm_pos      <= (act_pol == POL_POS) && drive_on;
            pwm_neg      <= (act_pol == POL_NEG) && drive_on;

            if (fetch_period && pwm_ctr == CAP_AT) begin
                shd_pol  <= in_pol;
                shd_duty <= in_duty;
                if (in_fault) begin
                    fault <= 1'b1;
                end
            end

            // Loads happen only at the wrap ending a fetch period; other wraps just drop the guard.
            if (wrap) begin
                div_ctr <= fetch_period ? '0 : div_ctr + 1'b1;
                if (fetch_period) begin
                    act_pol  <= shd_pol;
                    act_duty <= shd_duty;
                    guard    <= new_guard;
                    if (shd_pol != POL_ZERO) begin
                        last_pol <= shd_pol;
                    end
                end else begin
                    guard <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_halfwave_pwm.sv
// Self-checking bench for halfwave_pwm: directed sample table, enable/reset sequences and random samples
// compared against a period-level model of the output stage.
module tb_halfwave_pwm;

    localparam int PB   = 8;
    localparam int SD   = 4;
    localparam int DC   = 2;
    localparam int PER  = 256;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [PB-1:0] pos_in = '0;
    logic [PB-1:0] neg_in = '0;
    logic          sample_req;
    logic          pwm_pos;
    logic          pwm_neg;
    logic          period_start;
    logic          fault;

    always #5 clk = ~clk;

    halfwave_pwm #(.PWM_BITS(PB), .SAMPLE_DIV(SD), .DEAD_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pos_in(pos_in),
        .neg_in(neg_in),
        .sample_req(sample_req),
        .pwm_pos(pwm_pos),
        .pwm_neg(pwm_neg),
        .period_start(period_start),
        .fault(fault)
    );

    typedef struct {
        int   pos0, neg0, pos1, neg1;
        int   p1_pos, p1_neg, p2_pos, p2_neg, p5_pos, p5_neg;
        logic fault;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   spos [16];
    int   sneg [16];
    logic act_pos   [MAXC];
    logic act_neg   [MAXC];
    logic act_req   [MAXC];
    logic act_ps    [MAXC];
    logic act_fault [MAXC];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Polarity of fetch f: 0 silent, 1 positive, 2 negative.
    function automatic int pol_of(input int f);
        if (spos[f] != 0 && sneg[f] == 0) return 1;
        if (sneg[f] != 0 && spos[f] == 0) return 2;
        return 0;
    endfunction

    function automatic int duty_of(input int f);
        if (pol_of(f) == 1) return spos[f];
        if (pol_of(f) == 2) return sneg[f];
        return 0;
    endfunction

    // Expected pin for counter value c of period p: fetch f plays in periods SD*f+1 .. SD*f+SD.
    function automatic logic exp_pwm(input int want, input int p, input int c);
        int f, pol, last;
        bit grd;
        if (p == 0) return 1'b0;
        f    = (p - 1) / SD;
        pol  = pol_of(f);
        last = 0;
        for (int i = 0; i < f; i++) begin
            if (pol_of(i) != 0) last = pol_of(i);
        end
        grd = (p == SD * f + 1) && (pol != 0) && (pol != last);
        return (pol == want) && (c < duty_of(f)) && !(grd && c < DC);
    endfunction

    function automatic int count_win(input bit neg_pin, input int p);
        int n = 0;
        for (int c = 1; c <= PER; c++) begin
            if (neg_pin ? act_neg[p*PER+c] : act_pos[p*PER+c]) n++;
        end
        return n;
    endfunction

    task automatic applyReset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("reset_clear", 256'({sample_req, pwm_pos, pwm_neg, period_start, fault}), 256'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Runs np periods from a fresh enable, logging every cycle, then checks each period against the model.
    task automatic applyStimulus(input int np, input bit do_reset, input bit fault_carry);
        logic [255:0] ep, ap, en, an, er, ar, eps, aps;
        logic         ef;
        int           both;
        if (do_reset) applyReset();
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k <= np * PER; k++) begin
            @(negedge clk);
            if (k % (SD * PER) == 0) begin
                pos_in = PB'(spos[k / (SD * PER)]);
                neg_in = PB'(sneg[k / (SD * PER)]);
            end
            act_pos[k]   = pwm_pos;
            act_neg[k]   = pwm_neg;
            act_req[k]   = sample_req;
            act_ps[k]    = period_start;
            act_fault[k] = fault;
        end
        checkOutput("cycle0_pins", 256'({act_pos[0], act_neg[0]}), 256'(0));
        both = 0;
        for (int p = 0; p < np; p++) begin
            for (int c = 0; c < PER; c++) begin
                ep[c]  = exp_pwm(1, p, c);
                ap[c]  = act_pos[p*PER+c+1];
                en[c]  = exp_pwm(2, p, c);
                an[c]  = act_neg[p*PER+c+1];
                er[c]  = (p % SD == 0) && (c == PER - 4);
                ar[c]  = act_req[p*PER+c];
                eps[c] = (c == 0);
                aps[c] = act_ps[p*PER+c];
                if (ap[c] && an[c]) both++;
            end
            ef = fault_carry;
            for (int f = 0; SD * f <= p; f++) begin
                if (spos[f] != 0 && sneg[f] != 0) ef = 1'b1;
            end
            checkOutput($sformatf("p%0d_pwm_pos", p), ap, ep);
            checkOutput($sformatf("p%0d_pwm_neg", p), an, en);
            checkOutput($sformatf("p%0d_sample_req", p), ar, er);
            checkOutput($sformatf("p%0d_period_start", p), aps, eps);
            checkOutput($sformatf("p%0d_fault", p), 256'(act_fault[p*PER+PER-1]), 256'(ef));
        end
        checkOutput("pin_overlap", 256'(both), 256'(0));
    endtask

    initial begin
        vec_t vecs [7];
        int   nreq, nhigh;

        vecs[0] = '{0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   1'b0};
        vecs[1] = '{64,  0,   64,  0,   62,  0,   64,  0,   64,  0,   1'b0};
        vecs[2] = '{100, 0,   0,   100, 98,  0,   100, 0,   0,   98,  1'b0};
        vecs[3] = '{10,  20,  50,  0,   0,   0,   0,   0,   48,  0,   1'b1};
        vecs[4] = '{255, 0,   0,   0,   253, 0,   255, 0,   0,   0,   1'b0};
        vecs[5] = '{0,   1,   0,   1,   0,   0,   0,   1,   0,   1,   1'b0};
        vecs[6] = '{0,   200, 1,   0,   0,   198, 0,   200, 0,   0,   1'b0};

        for (int v = 0; v < 7; v++) begin
            spos[0] = vecs[v].pos0;
            sneg[0] = vecs[v].neg0;
            for (int i = 1; i < 16; i++) begin
                spos[i] = vecs[v].pos1;
                sneg[i] = vecs[v].neg1;
            end
            applyStimulus(9, 1'b1, 1'b0);
            nreq = 0;
            for (int k = 0; k <= 9 * PER; k++) if (act_req[k]) nreq++;
            checkOutput($sformatf("v%0d_p1_pos", v), 256'(count_win(1'b0, 1)), 256'(vecs[v].p1_pos));
            checkOutput($sformatf("v%0d_p1_neg", v), 256'(count_win(1'b1, 1)), 256'(vecs[v].p1_neg));
            checkOutput($sformatf("v%0d_p2_pos", v), 256'(count_win(1'b0, 2)), 256'(vecs[v].p2_pos));
            checkOutput($sformatf("v%0d_p2_neg", v), 256'(count_win(1'b1, 2)), 256'(vecs[v].p2_neg));
            checkOutput($sformatf("v%0d_p5_pos", v), 256'(count_win(1'b0, 5)), 256'(vecs[v].p5_pos));
            checkOutput($sformatf("v%0d_p5_neg", v), 256'(count_win(1'b1, 5)), 256'(vecs[v].p5_neg));
            checkOutput($sformatf("v%0d_fault_end", v), 256'(act_fault[9*PER]), 256'(vecs[v].fault));
            checkOutput($sformatf("v%0d_req_count", v), 256'(nreq), 256'(3));
        end

        // Random sample stream, including illegal and extreme magnitudes.
        for (int i = 0; i < 16; i++) begin
            int kind, mag;
            kind = int'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0:       mag = 1;
                1:       mag = 255;
                default: mag = int'($urandom_range(1, 255));
            endcase
            spos[i] = (kind == 0 || kind == 3) ? mag : 0;
            sneg[i] = (kind == 1 || kind == 3) ? int'($urandom_range(1, 255)) : 0;
            if (kind == 4) spos[i] = mag;
        end
        applyStimulus(25, 1'b1, 1'b0);

        // Drop enable mid-period while pwm_pos is high, then stay idle.
        applyReset();
        pos_in = 8'd200;
        neg_in = 8'd0;
        @(negedge clk);
        enable = 1'b1;
        repeat (PER + 101) @(negedge clk);
        checkOutput("pos_high_at_disable", 256'(pwm_pos), 256'(1));
        enable = 1'b0;
        @(negedge clk);
        checkOutput("off_next_cycle", 256'({sample_req, pwm_pos, pwm_neg, period_start}), 256'(0));
        nreq  = 0;
        nhigh = 0;
        repeat (3000) begin
            @(negedge clk);
            if (sample_req) nreq++;
            if (pwm_pos || pwm_neg || period_start) nhigh++;
        end
        checkOutput("idle_sample_req", 256'(nreq), 256'(0));
        checkOutput("idle_outputs", 256'(nhigh), 256'(0));

        // Re-enable without reset restarts from the entry values.
        for (int i = 0; i < 16; i++) begin
            spos[i] = 30;
            sneg[i] = 0;
        end
        applyStimulus(2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
